fb_read_sched: RTL and testbench

Frame-buffer read scheduler that sequences one frame readout per trigger. For each frame it issues address requests in a fixed order: frame info, image body in capped chunks, then statistics. Requests go out with fval and segment flags on an aval/ardy handshake. It sits between the frame-buffer write/ready logic and `fb_packet_divide`, which consumes its fval/aval/flags/addr/length stream.

---
 rtl/fb_read_sched.sv | 167 ++++++++++++++++
 tb/tb_fb_read_sched.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_read_sched.sv
// Frame-buffer read scheduler: one frame per accepted trigger, issuing info, capped
// image chunks and statistics requests on an aval/ardy handshake inside an fval envelope.
module fb_read_sched #(
  parameter int FRAME_BYTE_ADDR_WD = 27,
  parameter int INFO_SIZE          = 256,
  parameter int STATIS_SIZE        = 256,
  parameter int STATIS_VALID       = 1,
  parameter int MAX_REQ_LEN        = 4096,
  parameter int FVAL_LEAD          = 2,
  parameter int FVAL_TAIL          = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_stream_enable,
  input  logic                          i_frame_start,
  input  logic [FRAME_BYTE_ADDR_WD-1:0] iv_frame_base_addr,
  input  logic [FRAME_BYTE_ADDR_WD-1:0] iv_image_size,
  input  logic                          i_ardy,
  output logic                          o_fval,
  output logic                          o_aval,
  output logic                          o_info_flag,
  output logic                          o_image_flag,
  output logic                          o_statis_flag,
  output logic [FRAME_BYTE_ADDR_WD-1:0] ov_rd_addr,
  output logic [FRAME_BYTE_ADDR_WD-1:0] ov_rd_length,
  output logic                          o_busy,
  output logic                          o_frame_done,
  output logic                          o_start_drop
);

  localparam int AW = FRAME_BYTE_ADDR_WD;
  localparam logic [AW-1:0] INFO_LEN   = AW'(INFO_SIZE);
  localparam logic [AW-1:0] STATIS_LEN = AW'(STATIS_SIZE);
  localparam logic [AW-1:0] MAX_LEN    = AW'(MAX_REQ_LEN);
  localparam logic [15:0]   LEAD_LAST  = 16'(FVAL_LEAD - 1);
  localparam logic [15:0]   TAIL_LAST  = 16'(FVAL_TAIL - 1);

  typedef enum logic [2:0] {IDLE, LEAD, INFO, IMAGE, STATIS, TAIL} state_t;

  state_t        state;
  logic [15:0]   cnt;
  logic [AW-1:0] base;
  logic [AW-1:0] img_size;
  logic [AW-1:0] remaining;

  function automatic logic [AW-1:0] chunk_len(input logic [AW-1:0] rem);
    return (rem > MAX_LEN) ? MAX_LEN : rem;
  endfunction

  // The frame_done cycle still belongs to the finishing frame, so a start there is dropped.
  logic          start_ok;
  logic          xfer;
  logic [AW-1:0] rem_next;
  logic [AW-1:0] statis_addr;
  assign start_ok    = i_frame_start && i_stream_enable && (state == IDLE) && !o_frame_done;
  assign xfer        = o_aval && i_ardy;
  assign rem_next    = remaining - ov_rd_length;
  assign statis_addr = base + INFO_LEN + img_size;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      remaining     <= '0;
      o_fval        <= 1'b0;
      o_aval        <= 1'b0;
      o_info_flag   <= 1'b0;
      o_image_flag  <= 1'b0;
      o_statis_flag <= 1'b0;
      ov_rd_addr    <= '0;
      ov_rd_length  <= '0;
      o_busy        <= 1'b0;
      o_frame_done  <= 1'b0;
      o_start_drop  <= 1'b0;
    end else begin
      o_start_drop <= i_frame_start && !start_ok;
      o_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            base     <= iv_frame_base_addr;
            img_size <= iv_image_size;
            o_fval   <= 1'b1;
            o_busy   <= 1'b1;
            cnt      <= '0;
            state    <= LEAD;
          end
        end
        LEAD: begin
          if (cnt == LEAD_LAST) begin
            cnt          <= '0;
            state        <= INFO;
            o_aval       <= 1'b1;
            o_info_flag  <= 1'b1;
            ov_rd_addr   <= base;
            ov_rd_length <= INFO_LEN;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        INFO: begin
          if (xfer) begin
            o_info_flag <= 1'b0;
            if (img_size != '0) begin
              state        <= IMAGE;
              o_image_flag <= 1'b1;
              ov_rd_addr   <= base + INFO_LEN;
              ov_rd_length <= chunk_len(img_size);
              remaining    <= img_size;
            end else if (STATIS_VALID != 0) begin
              state         <= STATIS;
              o_statis_flag <= 1'b1;
              ov_rd_addr    <= statis_addr;
              ov_rd_length  <= STATIS_LEN;
            end else begin
              state  <= TAIL;
              o_aval <= 1'b0;
              cnt    <= '0;
            end
          end
        end
        IMAGE: begin
          if (xfer) begin
            remaining <= rem_next;
            if (rem_next != '0) begin
              ov_rd_addr   <= ov_rd_addr + ov_rd_length;
              ov_rd_length <= chunk_len(rem_next);
            end else begin
              o_image_flag <= 1'b0;
              if (STATIS_VALID != 0) begin
                state         <= STATIS;
                o_statis_flag <= 1'b1;
                ov_rd_addr    <= statis_addr;
                ov_rd_length  <= STATIS_LEN;
              end else begin
                state  <= TAIL;
                o_aval <= 1'b0;
                cnt    <= '0;
              end
            end
          end
        end
        STATIS: begin
          if (xfer) begin
            o_statis_flag <= 1'b0;
            o_aval        <= 1'b0;
            cnt           <= '0;
            state         <= TAIL;
          end
        end
        TAIL: begin
          if (cnt == TAIL_LAST) begin
            cnt          <= '0;
            o_fval       <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b1;
            state        <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_read_sched.sv
// Bench for fb_read_sched: randomized frames and handshakes checked against a
// request-list model derived from base, image size and segment rules.
module tb_fb_read_sched;
  localparam int AW = 27;

  logic          clk = 1'b0;
  logic          reset, en, start, ardy;
  logic [AW-1:0] base_in, size_in;

  logic          fval, aval, info_f, image_f, statis_f, busy, done, drop;
  logic [AW-1:0] addr, len;
  logic          ns_fval, ns_aval, ns_info_f, ns_image_f, ns_statis_f, ns_busy, ns_done, ns_drop;
  logic [AW-1:0] ns_addr, ns_len;

  fb_read_sched dut (
    .clk(clk), .reset(reset), .i_stream_enable(en), .i_frame_start(start),
    .iv_frame_base_addr(base_in), .iv_image_size(size_in), .i_ardy(ardy),
    .o_fval(fval), .o_aval(aval), .o_info_flag(info_f), .o_image_flag(image_f),
    .o_statis_flag(statis_f), .ov_rd_addr(addr), .ov_rd_length(len),
    .o_busy(busy), .o_frame_done(done), .o_start_drop(drop)
  );

  fb_read_sched #(.STATIS_VALID(0)) dut_ns (
    .clk(clk), .reset(reset), .i_stream_enable(en), .i_frame_start(start),
    .iv_frame_base_addr(base_in), .iv_image_size(size_in), .i_ardy(ardy),
    .o_fval(ns_fval), .o_aval(ns_aval), .o_info_flag(ns_info_f), .o_image_flag(ns_image_f),
    .o_statis_flag(ns_statis_f), .ov_rd_addr(ns_addr), .ov_rd_length(ns_len),
    .o_busy(ns_busy), .o_frame_done(ns_done), .o_start_drop(ns_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            seg;  // 0 info, 1 image, 2 statis
    logic [AW-1:0] addr;
    logic [AW-1:0] len;
  } req_t;

  req_t got[$];
  req_t got_ns[$];
  req_t exp[$];

  int total = 0;
  int bad = 0;
  int fval_cyc, busy_cyc, lead_cyc, done_cnt, drop_cnt, stall_bad, flag_bad;
  bit seen_aval;
  bit prev_stall = 1'b0;
  logic [AW-1:0] p_addr, p_len;
  logic [2:0]    p_flags;

  always @(negedge clk) begin
    if (fval) fval_cyc++;
    if (busy) busy_cyc++;
    if (fval && !aval && !seen_aval) lead_cyc++;
    if (aval) seen_aval = 1'b1;
    if (done) done_cnt++;
    if (drop) drop_cnt++;
    if (aval ? !$onehot({info_f, image_f, statis_f}) : ({info_f, image_f, statis_f} != 3'b000))
      flag_bad++;
    if (prev_stall && (!aval || addr !== p_addr || len !== p_len ||
                       {info_f, image_f, statis_f} !== p_flags))
      stall_bad++;
    prev_stall = aval && !ardy && !reset;
    p_addr = addr;
    p_len = len;
    p_flags = {info_f, image_f, statis_f};
    if (aval && ardy && !reset)
      got.push_back('{info_f ? 0 : (image_f ? 1 : 2), addr, len});
    if (ns_aval && ardy && !reset)
      got_ns.push_back('{ns_info_f ? 0 : (ns_image_f ? 1 : 2), ns_addr, ns_len});
  end

  task automatic clear_mon();
    got.delete();
    got_ns.delete();
    fval_cyc = 0; busy_cyc = 0; lead_cyc = 0; done_cnt = 0; drop_cnt = 0;
    stall_bad = 0; flag_bad = 0; seen_aval = 1'b0;
  endtask

  // Reference: info, then image split into MAX_REQ_LEN pieces, then optional statistics.
  function automatic void build_exp(input logic [AW-1:0] b, input int img, input bit sv);
    int rem;
    int off;
    int l;
    exp.delete();
    exp.push_back('{0, b, AW'(256)});
    rem = img;
    off = 0;
    while (rem > 0) begin
      l = (rem > 4096) ? 4096 : rem;
      exp.push_back('{1, AW'(b + AW'(256 + off)), AW'(l)});
      off += l;
      rem -= l;
    end
    if (sv) exp.push_back('{2, AW'(b + AW'(256 + img)), AW'(256)});
  endfunction

  function automatic bit seq_match(input bit use_ns);
    req_t q[$];
    q = use_ns ? got_ns : got;
    if (q.size() != exp.size()) return 1'b0;
    foreach (q[i])
      if (q[i].seg != exp[i].seg || q[i].addr !== exp[i].addr || q[i].len !== exp[i].len)
        return 1'b0;
    return 1'b1;
  endfunction

  // extra: 0 none, 1 extra start during IMAGE, 2 drop stream enable mid-frame
  task automatic run_frame(input logic [AW-1:0] b, input logic [AW-1:0] s, input bit rnd,
                           input int extra, output bit timed_out);
    int n;
    bit injected;
    clear_mon();
    @(posedge clk); #1;
    base_in = b; size_in = s; start = 1'b1; ardy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base_in = AW'($urandom); size_in = AW'($urandom);
    n = 0; timed_out = 1'b0; injected = 1'b0;
    while (done_cnt == 0 && !timed_out) begin
      ardy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (extra == 1 && image_f && !injected) begin
        start = 1'b1; injected = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (extra == 2 && n == 3) en = 1'b0;
      @(posedge clk); #1;
      n++;
      if (n > 3000) timed_out = 1'b1;
    end
    start = 1'b0; ardy = 1'b1; en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({fval, aval, info_f, image_f, statis_f, addr, len, busy, done, drop} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got fval=%0b aval=%0b addr=%h len=%0d busy=%0b, required all 0",
               fval, aval, addr, len, busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    bit to;
    run_frame(27'h1000, 27'd10000, 1'b0, 0, to);
    build_exp(27'h1000, 10000, 1'b1);
    total++; if (to) begin bad++; $display("FAIL basic_timeout: frame_done not seen, required within bound"); end
    total++; if (seq_match(0) !== 1'b1) begin bad++; $display("FAIL basic_seq: got %0d requests, required %0d", got.size(), exp.size()); end
    total++;
    if (got.size() < 5 || got[3].addr !== 27'h3100 || got[3].len !== 27'd1808 || got[4].addr !== 27'h3810) begin
      bad++; $display("FAIL basic_last_chunk: got %0d requests, required image (0x3100,1808) then statis 0x3810", got.size());
    end
    total++; if (fval_cyc !== 11) begin bad++; $display("FAIL basic_fval_cycles: got %0d required 11", fval_cyc); end
    total++; if (lead_cyc !== 2) begin bad++; $display("FAIL basic_lead: got %0d required 2", lead_cyc); end
    total++; if (busy_cyc !== 11) begin bad++; $display("FAIL basic_busy_cycles: got %0d required 11", busy_cyc); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done: got %0d pulses required 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    bit to;
    for (int k = 0; k < 3; k++) begin
      run_frame(27'h1000, 27'd10000, 1'b1, 0, to);
      build_exp(27'h1000, 10000, 1'b1);
      total++; if (to || seq_match(0) !== 1'b1) begin bad++; $display("FAIL bp_seq: got %0d requests timeout=%0b, required %0d", got.size(), to, exp.size()); end
      total++; if (stall_bad !== 0) begin bad++; $display("FAIL bp_stall_stable: got %0d violations required 0", stall_bad); end
      total++; if (flag_bad !== 0) begin bad++; $display("FAIL bp_flags: got %0d violations required 0", flag_bad); end
    end
  endtask

  task automatic test_edge_sizes();
    bit to;
    logic [AW-1:0] b;
    int s;
    run_frame(27'h40, 27'd0, 1'b1, 0, to);
    build_exp(27'h40, 0, 1'b1);
    total++; if (to || seq_match(0) !== 1'b1) begin bad++; $display("FAIL size0_seq: got %0d requests, required 2", got.size()); end
    run_frame(27'h40, 27'd4096, 1'b0, 0, to);
    build_exp(27'h40, 4096, 1'b1);
    total++; if (to || seq_match(0) !== 1'b1 || got.size() != 3) begin bad++; $display("FAIL size4096_seq: got %0d requests, required 3", got.size()); end
    for (int k = 0; k < 4; k++) begin
      b = AW'($urandom);
      s = (k == 0) ? 4097 : int'($urandom_range(1, 20000));
      run_frame(b, AW'(s), 1'b1, 0, to);
      build_exp(b, s, 1'b1);
      total++; if (to || seq_match(0) !== 1'b1) begin bad++; $display("FAIL rand_seq: base=%h size=%0d got %0d requests, required %0d", b, s, got.size(), exp.size()); end
    end
  endtask

  task automatic test_statis_skip();
    bit to;
    run_frame(27'h2000, 27'd5000, 1'b1, 0, to);
    build_exp(27'h2000, 5000, 1'b0);
    total++; if (to || seq_match(1) !== 1'b1) begin bad++; $display("FAIL nostatis_seq: got %0d requests, required %0d", got_ns.size(), exp.size()); end
    build_exp(27'h2000, 5000, 1'b1);
    total++; if (seq_match(0) !== 1'b1) begin bad++; $display("FAIL statis_seq: got %0d requests, required %0d", got.size(), exp.size()); end
  endtask

  task automatic test_wrap();
    bit to;
    run_frame(27'h7FFFF80, 27'd300, 1'b0, 0, to);
    build_exp(27'h7FFFF80, 300, 1'b1);
    total++; if (to || seq_match(0) !== 1'b1) begin bad++; $display("FAIL wrap_seq: got %0d requests, required %0d", got.size(), exp.size()); end
    total++;
    if (got.size() != 3 || got[0].addr !== 27'h7FFFF80 || got[1].addr !== 27'h80 || got[2].addr !== 27'h1AC) begin
      bad++; $display("FAIL wrap_addr: got %0d requests, required addrs 7FFFF80/80/1AC", got.size());
    end
  endtask

  task automatic test_start_drop();
    bit to;
    run_frame(27'h1000, 27'd10000, 1'b1, 1, to);
    build_exp(27'h1000, 10000, 1'b1);
    total++; if (to || seq_match(0) !== 1'b1) begin bad++; $display("FAIL drop_busy_seq: got %0d requests, required %0d", got.size(), exp.size()); end
    total++; if (drop_cnt !== 1) begin bad++; $display("FAIL drop_busy_pulse: got %0d pulses required 1", drop_cnt); end
    clear_mon();
    @(posedge clk); #1; en = 1'b0; start = 1'b1; base_in = 27'h10; size_in = 27'd100;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1; en = 1'b1;
    total++; if (drop_cnt !== 1 || fval_cyc !== 0) begin bad++; $display("FAIL drop_disabled: got drops=%0d fval_cycles=%0d, required 1 and 0", drop_cnt, fval_cyc); end
    run_frame(27'h3000, 27'd9000, 1'b1, 2, to);
    build_exp(27'h3000, 9000, 1'b1);
    total++; if (to || seq_match(0) !== 1'b1 || done_cnt !== 1) begin bad++; $display("FAIL disable_midframe: got %0d requests done=%0d, required %0d and 1", got.size(), done_cnt, exp.size()); end
  endtask

  task automatic test_done_edge();
    int n;
    clear_mon();
    @(posedge clk); #1; base_in = 27'h500; size_in = 27'd100; start = 1'b1; ardy = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL done_edge_wait: frame_done not seen, required within 200 cycles"); end
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    total++; if (fval !== 1'b0 || drop !== 1'b1) begin bad++; $display("FAIL done_edge_drop: got fval=%0b drop=%0b, required 0 and 1", fval, drop); end
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    total++; if (fval !== 1'b1 || busy !== 1'b1 || drop !== 1'b0) begin bad++; $display("FAIL done_edge_accept: got fval=%0b busy=%0b drop=%0b, required 1 1 0", fval, busy, drop); end
    n = 0;
    while (done !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL done_edge_second: frame_done not seen, required within 200 cycles"); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bit to;
    int n;
    clear_mon();
    @(posedge clk); #1; base_in = 27'h1000; size_in = 27'd10000; start = 1'b1; ardy = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (image_f !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    ardy = 1'b0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (image_f !== 1'b1 && n >= 100) begin bad++; $display("FAIL reset_mid_reach: IMAGE not reached, required within 100 cycles"); end
    else if ({fval, aval, info_f, image_f, statis_f, addr, len, busy, done, drop} !== '0) begin
      bad++; $display("FAIL reset_mid_outputs: got fval=%0b aval=%0b addr=%h len=%0d, required all 0", fval, aval, addr, len);
    end
    reset = 1'b0; ardy = 1'b1;
    run_frame(27'h1000, 27'd10000, 1'b1, 0, to);
    build_exp(27'h1000, 10000, 1'b1);
    total++; if (to || seq_match(0) !== 1'b1 || done_cnt !== 1) begin bad++; $display("FAIL reset_mid_restart: got %0d requests done=%0d, required %0d and 1", got.size(), done_cnt, exp.size()); end
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; start = 1'b0; ardy = 1'b1; base_in = '0; size_in = '0;
    clear_mon();
    test_reset();
    test_basic();
    test_backpressure();
    test_edge_sizes();
    test_statis_skip();
    test_wrap();
    test_start_drop();
    test_done_edge();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
